// File: rtl/rx_fifo_bus.sv
// Receive-side byte FIFO bridging the UART core's rx strobe to the CPU peripheral bus.
// Provides STATUS/DATA/CTRL registers, sticky overflow/timeout flags and a level interrupt.
module rx_fifo_bus #(
  parameter int DEPTH_LOG2  = 4,
  parameter int THRESH      = 8,
  parameter int TIMEOUT_CYC = 8680
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        rx_vld,
  input  logic [7:0]  rx_data,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [3:0]    ADDR_STATUS = 4'h8;
  localparam logic [3:0]    ADDR_DATA   = 4'hC;
  localparam logic [TW-1:0] TMO_MAX     = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_PRE     = TW'(TIMEOUT_CYC - 1);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  ovf, tmo;
  logic [TW-1:0]         timer, timer_nxt;

  logic rd_access, data_rd, ctrl_wr;
  logic flush, clr_ovf, clr_tmo;
  logic not_empty, full;
  logic pop, push_eff, ovf_set, tmo_set;
  logic unused_din;

  assign unused_din = ^din[31:3];

  assign rd_access = ce & ~we;
  assign data_rd   = rd_access & (addr == ADDR_DATA);
  assign ctrl_wr   = ce & we & (addr == ADDR_DATA);
  assign flush     = ctrl_wr & din[0];
  assign clr_ovf   = ctrl_wr & din[1];
  assign clr_tmo   = ctrl_wr & din[2];

  assign not_empty = (count != '0);
  assign full      = (count == CW'(DEPTH));

  // A pop frees the head slot, so a full FIFO can still accept a same-cycle push.
  assign pop      = data_rd & not_empty;
  assign push_eff = rx_vld & (~full | pop) & ~flush;
  assign ovf_set  = rx_vld & full & ~pop & ~flush;

  always_comb begin
    count_nxt = count;
    case ({push_eff, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    timer_nxt = timer;
    tmo_set   = 1'b0;
    if (flush || push_eff || pop || !not_empty) begin
      timer_nxt = '0;
    end else if (timer != TMO_MAX) begin
      timer_nxt = timer + 1'b1;
      tmo_set   = (timer == TMO_PRE);
    end
  end

  // NOTE: the byte storage is deliberately left out of reset; valid data is tracked
  // by the pointers and count, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= rx_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational logic above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      tmo    <= 1'b0;
      timer  <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_eff) wr_ptr <= wr_ptr + 1'b1;
        if (pop)      rd_ptr <= rd_ptr + 1'b1;
        count <= count_nxt;
      end

      if (clr_ovf)      ovf <= 1'b0;
      else if (ovf_set) ovf <= 1'b1;

      if (clr_tmo)      tmo <= 1'b0;
      else if (tmo_set) tmo <= 1'b1;

      timer <= timer_nxt;
    end
  end

  // NOTE: every output bit gets a default first so this block never infers a latch.
  always_comb begin
    dout = '0;
    if (rd_access) begin
      case (addr)
        ADDR_STATUS: begin
          dout[0]      = not_empty;
          dout[1]      = full;
          dout[2]      = ovf;
          dout[3]      = tmo;
          dout[8 +: CW] = count;
        end
        ADDR_DATA: begin
          dout[8] = not_empty;
          if (not_empty) dout[7:0] = mem[rd_ptr];
        end
        default: dout = '0;
      endcase
    end
  end

  assign irq = (count >= CW'(THRESH)) | ovf | tmo;

endmodule

// File: tb/tb_rx_fifo_bus.sv
// Directed, table-driven bench for rx_fifo_bus at default parameters (DEPTH 16,
// THRESH 8, TIMEOUT_CYC 8680); expected values are hand-computed constants.
module tb_rx_fifo_bus;

  localparam int T = 8680;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        rx_vld;
  logic [7:0]  rx_data;
  logic        irq;

  int total = 0;
  int bad   = 0;

  rx_fifo_bus dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .rx_vld  (rx_vld),
    .rx_data (rx_data),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] din;
    logic        vld;
    logic [7:0]  data;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive, sample at negedge, commit on posedge, return idle.
  task automatic cyc(input logic c, input logic w, input logic [3:0] a, input logic [31:0] d,
                     input logic v, input logic [7:0] b,
                     output logic [31:0] rd, output logic ir);
    ce = c; we = w; addr = a; din = d; rx_vld = v; rx_data = b;
    @(negedge clk);
    rd = dout;
    ir = irq;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0; addr = 4'h0; din = 32'h0; rx_vld = 1'b0; rx_data = 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    logic [31:0] x;
    logic        y;
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, b, x, y);
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] x);
    logic y;
    cyc(1'b1, 1'b0, a, 32'h0, 1'b0, 8'h00, x, y);
  endtask

  task automatic ctrl(input logic [31:0] d);
    logic [31:0] x;
    logic        y;
    cyc(1'b1, 1'b1, 4'hC, d, 1'b0, 8'h00, x, y);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    logic        q;
    logic [7:0]  b;

    //  ce   we   addr   din    vld  data   exp_dout      exp_irq
    vecs[0]  = '{1'b1, 1'b0, 4'h8, 32'h0, 1'b0, 8'h00, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 8'h41, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 8'h42, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 8'h43, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 4'h8, 32'h0, 1'b0, 8'h00, 32'h0000_0301, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'hC, 32'h0, 1'b0, 8'h00, 32'h0000_0141, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 4'hC, 32'h0, 1'b0, 8'h00, 32'h0000_0142, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 4'hC, 32'h0, 1'b0, 8'h00, 32'h0000_0143, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 4'hC, 32'h0, 1'b0, 8'h00, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'h8, 32'h0, 1'b0, 8'h00, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 4'h4, 32'h0, 1'b1, 8'h55, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 4'h8, 32'h7, 1'b0, 8'h00, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 4'h8, 32'h0, 1'b0, 8'h00, 32'h0000_0101, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 4'hC, 32'h0, 1'b1, 8'h66, 32'h0000_0155, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 4'h8, 32'h0, 1'b0, 8'h00, 32'h0000_0101, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 4'hC, 32'h0, 1'b0, 8'h00, 32'h0000_0166, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 4'hC, 32'h0, 1'b1, 8'h77, 32'h0000_0000, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 4'h8, 32'h0, 1'b0, 8'h00, 32'h0000_0101, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 4'hC, 32'h0, 1'b0, 8'h00, 32'h0000_0177, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 8'h00, 32'h0000_0000, 1'b0};

    rst = 1'b0; ce = 1'b0; we = 1'b0; addr = 4'h0; din = 32'h0; rx_vld = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dout", dout, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic push/pop, unmapped offsets, empty-read with push.
    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].vld, vecs[i].data, r, q);
      check($sformatf("vec%0d_dout", i), r, vecs[i].exp_dout);
      check($sformatf("vec%0d_irq", i), {31'b0, q}, {31'b0, vecs[i].exp_irq});
    end

    // Threshold boundary, clear-beats-set for ovf, then overflow.
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      if (i == 7) check("irq_below_thresh", {31'b0, irq}, 32'h0);
      if (i == 8) check("irq_at_thresh", {31'b0, irq}, 32'h1);
    end
    rd_reg(4'h8, r);
    check("full_status", r, 32'h0000_1003);
    cyc(1'b1, 1'b1, 4'hC, 32'h2, 1'b1, 8'h99, r, q);
    rd_reg(4'h8, r);
    check("ovf_clear_beats_set", r, 32'h0000_1003);
    push(8'd17);
    rd_reg(4'h8, r);
    check("overflow_status", r, 32'h0000_1007);
    check("overflow_irq", {31'b0, irq}, 32'h1);
    rd_reg(4'hC, r);
    check("overflow_first_byte", r, 32'h0000_0101);
    ctrl(32'h3);
    rd_reg(4'h8, r);
    check("flush_clr_status", r, 32'h0);
    check("flush_clr_irq", {31'b0, irq}, 32'h0);

    // Full FIFO with same-cycle push and pop.
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    cyc(1'b1, 1'b0, 4'hC, 32'h0, 1'b1, 8'hAA, r, q);
    check("full_pushpop_head", r, 32'h0000_0110);
    rd_reg(4'h8, r);
    check("full_pushpop_status", r, 32'h0000_1003);
    for (int i = 1; i < 16; i++) begin
      rd_reg(4'hC, r);
      check($sformatf("drain%0d", i), r, 32'h100 | 32'(8'h10 + i));
    end
    rd_reg(4'hC, r);
    check("drain_tail_aa", r, 32'h0000_01AA);
    rd_reg(4'h8, r);
    check("drain_empty", r, 32'h0);

    // Idle timeout, clear, and saturation without re-set.
    push(8'h21);
    idle(T - 1);
    check("tmo_not_yet", {31'b0, irq}, 32'h0);
    idle(1);
    check("tmo_irq", {31'b0, irq}, 32'h1);
    rd_reg(4'h8, r);
    check("tmo_status", r, 32'h0000_0109);
    ctrl(32'h4);
    rd_reg(4'h8, r);
    check("tmo_cleared_status", r, 32'h0000_0101);
    check("tmo_cleared_irq", {31'b0, irq}, 32'h0);
    idle(20);
    check("tmo_saturated_no_reset", {31'b0, irq}, 32'h0);
    rd_reg(4'hC, r);
    check("tmo_pop", r, 32'h0000_0121);

    // A pop at timer = TIMEOUT_CYC-1 restarts the idle count.
    push(8'h31);
    push(8'h32);
    idle(T - 1);
    rd_reg(4'hC, r);
    check("late_pop_data", r, 32'h0000_0131);
    check("late_pop_irq", {31'b0, irq}, 32'h0);
    idle(T - 1);
    check("late_pop_no_tmo", {31'b0, irq}, 32'h0);
    idle(1);
    check("late_pop_tmo_after", {31'b0, irq}, 32'h1);
    ctrl(32'h5);
    rd_reg(4'h8, r);
    check("flush_tmo_status", r, 32'h0);

    // Clear tmo in the very cycle it would be set.
    push(8'h41);
    idle(T - 1);
    ctrl(32'h4);
    rd_reg(4'h8, r);
    check("tmo_clear_beats_set", r, 32'h0000_0101);
    check("tmo_clear_beats_set_irq", {31'b0, irq}, 32'h0);
    rd_reg(4'hC, r);
    check("tmo_clear_pop", r, 32'h0000_0141);

    // Flush beats a same-cycle push; then pointer wrap over 40 pairs.
    for (int i = 0; i < 12; i++) push(8'(i));
    cyc(1'b1, 1'b1, 4'hC, 32'h1, 1'b1, 8'hEE, r, q);
    rd_reg(4'h8, r);
    check("flush_push_status", r, 32'h0);
    rd_reg(4'hC, r);
    check("flush_push_discarded", r, 32'h0);
    for (int i = 0; i < 40; i++) begin
      b = 8'(i * 7 + 3);
      push(b);
      rd_reg(4'hC, r);
      check($sformatf("wrap%0d", i), r, 32'h100 | 32'(b));
    end
    rd_reg(4'h8, r);
    check("wrap_end_status", r, 32'h0);

    // Reset asserted mid-fill with a STATUS read in flight.
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    rd_reg(4'h8, r);
    check("prereset_status", r, 32'h0000_0501);
    ce = 1'b1; we = 1'b0; addr = 4'h8;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_dout", dout, 32'h0);
    check("midreset_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("postreset_dout", dout, 32'h0);
    ce = 1'b0; addr = 4'h0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    push(8'h61);
    rd_reg(4'h8, r);
    check("resume_status", r, 32'h0000_0101);
    rd_reg(4'hC, r);
    check("resume_data", r, 32'h0000_0161);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
